// File: rtl/lwc_if.sv
// lwc_if: public (pdi), secret (sdi) and output (do) word streams between host wrapper and lwc core.
interface lwc_if #(
    parameter int BUSW = 32
);
    logic [BUSW-1:0] pdi_data;
    logic            pdi_valid;
    logic            pdi_ready;
    logic [BUSW-1:0] sdi_data;
    logic            sdi_valid;
    logic            sdi_ready;
    logic [BUSW-1:0] do_data;
    logic            do_valid;
    logic            do_ready;
    logic            do_last;

    modport master (
        output pdi_data, pdi_valid, sdi_data, sdi_valid, do_ready,
        input  pdi_ready, sdi_ready, do_data, do_valid, do_last
    );

    modport slave (
        input  pdi_data, pdi_valid, sdi_data, sdi_valid, do_ready,
        output pdi_ready, sdi_ready, do_data, do_valid, do_last
    );
endinterface

// File: rtl/lwc.sv
// lwc: LWC-API style authenticated-encryption core with a word-wise XOR keystream and XOR tag.
// Build option LWC_DEC_EN: defined enables decryption with tag verification; undefined rejects DEC.
module lwc #(
    parameter int BUSW = 32
) (
    input  logic clk,
    input  logic rst_n,
    lwc_if.slave bus
);
    localparam logic [3:0] OP_LDKEY  = 4'h4;
    localparam logic [3:0] OP_ACTKEY = 4'h7;
    localparam logic [3:0] OP_ENC    = 4'h2;
    localparam logic [3:0] OP_DEC    = 4'h3;
    localparam logic [3:0] T_AD      = 4'h1;
    localparam logic [3:0] T_PT      = 4'h4;
    localparam logic [3:0] T_CT      = 4'h5;
    localparam logic [3:0] T_NPUB    = 4'hD;
    localparam logic [BUSW-1:0] TAG_HDR = 32'h8300_0010;
    localparam logic [BUSW-1:0] ST_OK   = 32'hE000_0000;
    localparam logic [BUSW-1:0] ST_FAIL = 32'hF000_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_KEY_HDR, S_KEY_DATA, S_SEG_HDR, S_SEG_DATA,
        S_OUT_HDR, S_TAG_IN, S_TAG_OUT, S_STATUS
    } state_e;

    state_e          state_q, state_d, end_state_s;
    logic            run_q;
    logic [BUSW-1:0] kst_q [4];
    logic [BUSW-1:0] kst_d [4];
    logic [BUSW-1:0] key_q [4];
    logic [BUSW-1:0] key_d [4];
    logic [BUSW-1:0] n_q [4];
    logic [BUSW-1:0] n_d [4];
    logic [BUSW-1:0] a_q [4];
    logic [BUSW-1:0] a_d [4];
    logic [BUSW-1:0] tag_s [4];
    logic            dec_q, dec_d, fail_q, fail_d, last_q, last_d;
    logic [3:0]      type_q, type_d;
    logic [27:0]     hdr_q, hdr_d;
    logic [15:0]     rem_q, rem_d;
    logic [1:0]      j_q, j_d, tidx_s;
    logic [2:0]      cnt_q, cnt_d;
    logic [BUSW-1:0] do_data_q, do_data_d;
    logic            do_valid_q, do_valid_d, do_last_q, do_last_d;
    logic            out_free_s, pdi_ready_s, sdi_ready_s, pdi_take_s, sdi_take_s;
    logic [BUSW-1:0] in_mw_s, ct_s;

    // Keep only the first rem bytes of a word (byte 0 is the most significant).
    function automatic logic [BUSW-1:0] mask_word(input logic [BUSW-1:0] w, input logic [15:0] rem);
        logic [BUSW-1:0] m;
        if (rem >= 16'd4) begin
            m = w;
        end else begin
            case (rem[1:0])
                2'd1:    m = {w[31:24], 24'h00_0000};
                2'd2:    m = {w[31:16], 16'h0000};
                2'd3:    m = {w[31:8], 8'h00};
                default: m = 32'h0000_0000;
            endcase
        end
        return m;
    endfunction

    // Segments whose data words are transformed and echoed on do.
    function automatic logic seg_io(input logic [3:0] t, input logic dec);
`ifdef LWC_DEC_EN
        return dec ? (t == T_CT) : (t == T_PT);
`else
        return !dec && (t == T_PT);
`endif
    endfunction

    assign out_free_s    = !do_valid_q || bus.do_ready;
    assign pdi_take_s    = bus.pdi_valid && pdi_ready_s;
    assign sdi_take_s    = bus.sdi_valid && sdi_ready_s;
    assign tidx_s        = cnt_q[1:0] - 2'd1;
    assign bus.pdi_ready = pdi_ready_s;
    assign bus.sdi_ready = sdi_ready_s;
    assign bus.do_data   = do_data_q;
    assign bus.do_valid  = do_valid_q;
    assign bus.do_last   = do_last_q;

    // Expected tag words and the state entered after the Last segment.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tag_s[k] = a_q[k] ^ key_q[k] ^ n_q[k];
        end
`ifdef LWC_DEC_EN
        end_state_s = dec_q ? S_TAG_IN : S_TAG_OUT;
`else
        end_state_s = dec_q ? S_STATUS : S_TAG_OUT;
`endif
    end

    // Input handshakes; IDLE gives the secret key path priority over pdi.
    always_comb begin
        pdi_ready_s = 1'b0;
        sdi_ready_s = 1'b0;
        if (run_q) begin
            case (state_q)
                S_IDLE: begin
                    sdi_ready_s = 1'b1;
                    pdi_ready_s = !bus.sdi_valid;
                end
                S_KEY_HDR, S_KEY_DATA: sdi_ready_s = 1'b1;
                S_SEG_HDR:             pdi_ready_s = 1'b1;
                S_SEG_DATA:            pdi_ready_s = seg_io(type_q, dec_q) ? out_free_s : 1'b1;
`ifdef LWC_DEC_EN
                S_TAG_IN:              pdi_ready_s = 1'b1;
`endif
                default: begin
                    pdi_ready_s = 1'b0;
                    sdi_ready_s = 1'b0;
                end
            endcase
        end else begin
            pdi_ready_s = 1'b0;
            sdi_ready_s = 1'b0;
        end
    end

    // Protocol FSM next state, datapath updates and output slot loading.
    always_comb begin
        state_d = state_q;  kst_d = kst_q;  key_d = key_q;  n_d = n_q;  a_d = a_q;
        dec_d = dec_q;  fail_d = fail_q;  last_d = last_q;  type_d = type_q;  hdr_d = hdr_q;
        rem_d = rem_q;  j_d = j_q;  cnt_d = cnt_q;  do_data_d = do_data_q;
        in_mw_s = mask_word(bus.pdi_data, rem_q);
        ct_s    = mask_word(bus.pdi_data ^ key_q[j_q] ^ n_q[j_q], rem_q);
        if (do_valid_q && bus.do_ready) begin
            do_valid_d = 1'b0;
            do_last_d  = 1'b0;
        end else begin
            do_valid_d = do_valid_q;
            do_last_d  = do_last_q;
        end
        case (state_q)
            S_IDLE: begin
                if (sdi_take_s) begin
                    cnt_d   = 3'd0;
                    state_d = (bus.sdi_data[31:28] == OP_LDKEY) ? S_KEY_HDR : S_IDLE;
                end else if (pdi_take_s) begin
                    case (bus.pdi_data[31:28])
                        OP_ACTKEY: key_d = kst_q;
                        OP_ENC, OP_DEC: begin
                            n_d   = '{default: '0};
                            a_d   = '{default: '0};
                            dec_d = (bus.pdi_data[31:28] == OP_DEC);
`ifdef LWC_DEC_EN
                            fail_d = 1'b0;
`else
                            fail_d = (bus.pdi_data[31:28] == OP_DEC);
`endif
                            state_d = S_SEG_HDR;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_KEY_HDR: state_d = sdi_take_s ? S_KEY_DATA : S_KEY_HDR;
            S_KEY_DATA: begin
                if (sdi_take_s) begin
                    kst_d[cnt_q[1:0]] = bus.sdi_data;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd3) ? S_IDLE : S_KEY_DATA;
                end else begin
                    state_d = S_KEY_DATA;
                end
            end
            S_SEG_HDR: begin
                if (pdi_take_s) begin
                    type_d = bus.pdi_data[31:28];
                    last_d = bus.pdi_data[24];
                    hdr_d  = bus.pdi_data[27:0];
                    rem_d  = bus.pdi_data[15:0];
                    j_d    = 2'd0;
                    cnt_d  = 3'd0;
                    if (seg_io(bus.pdi_data[31:28], dec_q)) state_d = S_OUT_HDR;
                    else if (bus.pdi_data[15:0] != 16'd0)    state_d = S_SEG_DATA;
                    else if (bus.pdi_data[24])               state_d = end_state_s;
                    else                                     state_d = S_SEG_HDR;
                end else begin
                    state_d = S_SEG_HDR;
                end
            end
            S_OUT_HDR: begin
                if (out_free_s) begin
                    do_data_d  = {(dec_q ? T_PT : T_CT), hdr_q};
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b0;
                    if (rem_q != 16'd0) state_d = S_SEG_DATA;
                    else if (last_q)    state_d = end_state_s;
                    else                state_d = S_SEG_HDR;
                end else begin
                    state_d = S_OUT_HDR;
                end
            end
            S_SEG_DATA: begin
                if (pdi_take_s) begin
                    case (type_q)
                        T_NPUB: n_d[j_q] = in_mw_s;
                        T_AD:   a_d[j_q] = a_q[j_q] ^ in_mw_s;
                        default: begin
                            if (seg_io(type_q, dec_q)) begin
                                do_data_d  = ct_s;
                                do_valid_d = 1'b1;
                                do_last_d  = 1'b0;
                                a_d[j_q]   = a_q[j_q] ^ (dec_q ? in_mw_s : ct_s);
                            end else begin
                                a_d[j_q] = a_q[j_q];
                            end
                        end
                    endcase
                    j_d = j_q + 2'd1;
                    if (rem_q <= 16'd4) begin
                        rem_d   = 16'd0;
                        state_d = last_q ? end_state_s : S_SEG_HDR;
                    end else begin
                        rem_d   = rem_q - 16'd4;
                        state_d = S_SEG_DATA;
                    end
                end else begin
                    state_d = S_SEG_DATA;
                end
            end
`ifdef LWC_DEC_EN
            S_TAG_IN: begin
                if (pdi_take_s) begin
                    if ((cnt_q != 3'd0) && (bus.pdi_data != tag_s[tidx_s])) fail_d = 1'b1;
                    else                                                    fail_d = fail_q;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd4) ? S_STATUS : S_TAG_IN;
                end else begin
                    state_d = S_TAG_IN;
                end
            end
`endif
            S_TAG_OUT: begin
                if (out_free_s) begin
                    do_data_d  = (cnt_q == 3'd0) ? TAG_HDR : tag_s[tidx_s];
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b0;
                    cnt_d      = cnt_q + 3'd1;
                    state_d    = (cnt_q == 3'd4) ? S_STATUS : S_TAG_OUT;
                end else begin
                    state_d = S_TAG_OUT;
                end
            end
            S_STATUS: begin
                if (out_free_s) begin
                    do_data_d  = fail_q ? ST_FAIL : ST_OK;
                    do_valid_d = 1'b1;
                    do_last_d  = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_STATUS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, key/nonce/accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;  run_q <= 1'b0;
            kst_q <= '{default: '0};  key_q <= '{default: '0};
            n_q <= '{default: '0};    a_q <= '{default: '0};
            dec_q <= 1'b0;  fail_q <= 1'b0;  last_q <= 1'b0;  type_q <= 4'h0;
            hdr_q <= 28'h0;  rem_q <= 16'h0;  j_q <= 2'd0;  cnt_q <= 3'd0;
            do_data_q <= 32'h0;  do_valid_q <= 1'b0;  do_last_q <= 1'b0;
        end else begin
            state_q <= state_d;  run_q <= 1'b1;
            kst_q <= kst_d;  key_q <= key_d;  n_q <= n_d;  a_q <= a_d;
            dec_q <= dec_d;  fail_q <= fail_d;  last_q <= last_d;  type_q <= type_d;
            hdr_q <= hdr_d;  rem_q <= rem_d;  j_q <= j_d;  cnt_q <= cnt_d;
            do_data_q <= do_data_d;  do_valid_q <= do_valid_d;  do_last_q <= do_last_d;
        end
    end
endmodule

// File: tb/tb_lwc.sv
// tb_lwc: directed vectors with hand-computed expectations for the lwc core.
module tb_lwc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] got_q [$];
    logic [32:0] exp_q [$];
    logic [31:0] nonce [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    lwc_if bus ();
    lwc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.do_valid && bus.do_ready) got_q.push_back({bus.do_last, bus.do_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic send_pdi(input logic [31:0] w);
        int n = 0;
        bus.pdi_data  = w;
        bus.pdi_valid = 1'b1;
        @(negedge clk);
        while (!bus.pdi_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pdi_ready) check_eq("pdi_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.pdi_valid = 1'b0;
    endtask

    task automatic send_sdi(input logic [31:0] w);
        int n = 0;
        bus.sdi_data  = w;
        bus.sdi_valid = 1'b1;
        @(negedge clk);
        while (!bus.sdi_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.sdi_ready) check_eq("sdi_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.sdi_valid = 1'b0;
    endtask

    task automatic expect_w(input logic [31:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    task automatic wait_done();
        int n = 0;
        logic seen;
        seen = 1'b0;
        while (!seen && n < 500) begin
            @(negedge clk);
            n++;
            seen = (got_q.size() != 0) && (got_q[got_q.size() - 1][32] === 1'b1);
        end
        check_eq("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic compare_out(input string tag);
        logic [63:0] g;
        check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? 64'(got_q[i]) : 64'hFFFF_FFFF_FFFF_FFFF;
            check_eq($sformatf("%s_w%0d", tag, i), g, 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic load_key();
        logic [31:0] kw [6] = '{32'h4000_0000, 32'hC200_0010, 32'h0001_0203,
                                32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F};
        for (int i = 0; i < 6; i++) begin
            send_sdi(kw[i]);
            check_eq($sformatf("key_sdi_ready%0d", i), 64'(bus.sdi_ready), 64'd1);
        end
        check_eq("key_no_do_valid", 64'(bus.do_valid), 64'd0);
        check_eq("key_no_output", 64'(got_q.size()), 64'd0);
    endtask

    task automatic run_enc2(input string tag);
        send_pdi(32'h2000_0000);
        send_pdi(32'hD200_0010);
        for (int i = 0; i < 4; i++) send_pdi(nonce[i]);
        send_pdi(32'h1200_0000);
        send_pdi(32'h4300_0004);
        send_pdi(32'hDEAD_BEEF);
        wait_done();
        expect_w(32'h5300_0004, 1'b0);
        expect_w(32'hCFBD_ADFD, 1'b0);
        expect_w(32'h8300_0010, 1'b0);
        expect_w(32'hDEAD_BEEF, 1'b0);
        expect_w(32'h2627_2425, 1'b0);
        expect_w(32'h3B3A_3938, 1'b0);
        expect_w(32'h4849_4A4B, 1'b0);
        expect_w(32'hE000_0000, 1'b1);
        compare_out(tag);
    endtask

    task automatic run_dec(input string tag, input logic [31:0] last_tag, input logic [31:0] status);
        send_pdi(32'h3000_0000);
        send_pdi(32'hD200_0010);
        for (int i = 0; i < 4; i++) send_pdi(nonce[i]);
        send_pdi(32'h1200_0000);
        send_pdi(32'h5300_0004);
        send_pdi(32'hCFBD_ADFD);
`ifdef LWC_DEC_EN
        send_pdi(32'h8300_0010);
        send_pdi(32'hDEAD_BEEF);
        send_pdi(32'h2627_2425);
        send_pdi(32'h3B3A_3938);
        send_pdi(last_tag);
        wait_done();
        expect_w(32'h4300_0004, 1'b0);
        expect_w(32'hDEAD_BEEF, 1'b0);
        expect_w(status, 1'b1);
`else
        wait_done();
        check_eq({tag, "_unused_tag"}, 64'(last_tag != 32'h0), 64'd1);
        expect_w(status, 1'b1);
`endif
        compare_out(tag);
    endtask

    initial begin
        logic [31:0] w;
        bus.pdi_valid = 1'b0;
        bus.pdi_data  = 32'h0;
        bus.sdi_valid = 1'b0;
        bus.sdi_data  = 32'h0;
        bus.do_ready  = 1'b1;
        #2;
        check_eq("rst_pdi_ready", 64'(bus.pdi_ready), 64'd0);
        check_eq("rst_sdi_ready", 64'(bus.sdi_ready), 64'd0);
        check_eq("rst_do_valid", 64'(bus.do_valid), 64'd0);
        check_eq("rst_do_last", 64'(bus.do_last), 64'd0);
        check_eq("rst_do_data", 64'(bus.do_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_sdi_ready", 64'(bus.sdi_ready), 64'd1);
        check_eq("post_rst_pdi_ready", 64'(bus.pdi_ready), 64'd1);

        load_key();

        // ENC: 32-byte AD, 31-byte PT (with a 5-cycle output stall), then empty Last PT
        send_pdi(32'h7000_0000);
        send_pdi(32'h2000_0000);
        send_pdi(32'h1200_0020);
        for (int i = 0; i < 8; i++) send_pdi(32'hA000_0000 + 32'(i));
        send_pdi(32'h4200_001F);
        for (int i = 0; i < 8; i++) begin
            w = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
            send_pdi(w);
            if (i == 4) begin
                bus.do_ready  = 1'b0;
                bus.pdi_data  = 32'h1415_1617;
                bus.pdi_valid = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check_eq("stall_do_data", 64'(bus.do_data), 64'h1010_1010);
                    check_eq("stall_pdi_ready", 64'(bus.pdi_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                bus.do_ready = 1'b1;
            end
        end
        send_pdi(32'h4100_0000);
        wait_done();
        expect_w(32'h5200_001F, 1'b0);
        for (int i = 0; i < 4; i++) expect_w(32'h0000_0000, 1'b0);
        for (int i = 0; i < 3; i++) expect_w(32'h1010_1010, 1'b0);
        expect_w(32'h1010_1000, 1'b0);
        expect_w(32'h5100_0000, 1'b0);
        expect_w(32'h8300_0010, 1'b0);
        expect_w(32'h1011_1217, 1'b0);
        expect_w(32'h1415_1613, 1'b0);
        expect_w(32'h1819_1A1F, 1'b0);
        expect_w(32'h1C1D_1E0B, 1'b0);
        expect_w(32'hE000_0000, 1'b1);
        compare_out("enc_ad_pt");

        run_enc2("enc_npub");

`ifdef LWC_DEC_EN
        run_dec("dec_ok", 32'h4849_4A4B, 32'hE000_0000);
        run_dec("dec_badtag", 32'h4849_4A4A, 32'hF000_0000);
`else
        run_dec("dec_rejected", 32'h4849_4A4B, 32'hF000_0000);
`endif

        // Reset in the middle of a PT segment, then a fresh key load and ENC
        send_pdi(32'h2000_0000);
        send_pdi(32'h4200_001F);
        send_pdi(32'h0001_0203);
        send_pdi(32'h0405_0607);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pdi_ready", 64'(bus.pdi_ready), 64'd0);
        check_eq("midrst_sdi_ready", 64'(bus.sdi_ready), 64'd0);
        check_eq("midrst_do_valid", 64'(bus.do_valid), 64'd0);
        check_eq("midrst_do_last", 64'(bus.do_last), 64'd0);
        check_eq("midrst_do_data", 64'(bus.do_data), 64'd0);
        @(negedge clk);
        got_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_key();
        send_pdi(32'h7000_0000);
        run_enc2("enc_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lwc.md
# lwc

Single-clock NIST-LWC-API-style authenticated-encryption core with a BUSW-bit public data input (pdi), secret data input (sdi) and data output (do). It parses the instruction/segment-header protocol, loads and activates a 128-bit key, and processes nonce, AD and message segments through a lightweight word-wise XOR keystream/tag datapath. It is the top-level crypto block seen by the host bus wrapper.

## Interface
- BUSW, 32, bus width in bits; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- pdi_data  in  BUSW  public instructions, headers and data (byte 0 in bits [31:24]).
- pdi_valid  in  1  pdi word valid.
- pdi_ready  out  1  pdi word accepted when pdi_valid && pdi_ready.
- sdi_data  in  BUSW  secret instructions, key header and key words.
- sdi_valid  in  1  sdi word valid.
- sdi_ready  out  1  sdi word accepted when sdi_valid && sdi_ready.
- do_data  out  BUSW  output headers, data, tag, status.
- do_valid  out  1  do word valid; held stable until do_ready.
- do_ready  in  1  sink accepts do word.
- do_last  out  1  marks the status word (final word of an operation).

## Operation
- Instruction word: opcode in [31:28]: LDKEY=4, ACTKEY=7, ENC=2, DEC=3; other bits ignored. Any other opcode is discarded (one word consumed).
- Segment header: type [31:28] (AD=1, PT=4, CT=5, TAG=8, KEY=C, NPUB=D), flags [27:24] (bit0 Last), length in bytes [15:0]; data words = ceil(length/4).
- States: IDLE, KEY_HDR, KEY_DATA, INSTR, SEG_HDR, SEG_DATA, OUT_HDR, TAG_IN, TAG_OUT, STATUS.
- IDLE: sdi_ready=1 while no operation active; LDKEY on sdi -> KEY_HDR -> KEY_DATA reads 4 words into staging key K[0..3]. ACTKEY on pdi copies staging key to active key.
- ENC/DEC on pdi: clear nonce N[0..3] and tag accumulator A[0..3] to 0, record mode, go to SEG_HDR.
- Segment data word index i restarts at 0 per segment; j = i mod 4; words masked: bytes beyond segment length forced to 0.
- NPUB: N[j] <= word. AD: A[j] ^= masked word.
- PT (ENC) / CT (DEC): first emit header with type CT (ENC) or PT (DEC), same flags and length; then per word out = masked(in ^ K[j] ^ N[j]); A[j] ^= masked CT word (output for ENC, input for DEC).
- Length 0 segment: header consumed, no data; for PT/CT the output header is still emitted.
- Segment with Last flag ends the message. ENC: emit TAG header 0x83000010 then T[j]=A[j]^K[j]^N[j], j=0..3, then status. DEC: read TAG header + 4 tag words, compare with computed T.
- Status word: 0xE0000000 success, 0xF0000000 tag mismatch; do_last=1 on it; then return to IDLE.
- Unknown segment type: data words consumed and discarded.

## Timing
- Reset values: pdi_ready=0, sdi_ready=0, do_valid=0, do_last=0, do_data=0; keys, N, A cleared; state IDLE.
- First cycle after reset release: sdi_ready=1, pdi_ready=1 (IDLE accepts either).
- Single registered output slot: in pass-through states pdi_ready = !do_valid || do_ready; CT/PT word appears on do_data the cycle after acceptance (1-cycle latency), full throughput 1 word/cycle.
- Input words consumed only in header/data states; pdi_ready=0 during OUT_HDR, TAG_OUT, STATUS.
- do_valid with do_ready low: do_data/do_last frozen, no input accepted.
- Reset asserted mid-operation: everything returns to reset values immediately; staging and active keys lost.
- sdi_ready=0 whenever an ENC/DEC operation is in progress.

## Configuration
- LWC_DEC_EN: defined -> DEC supported as above. Undefined -> DEC opcode treated as unknown segment stream: remaining segments consumed, and after the Last segment only status 0xF0000000 (do_last=1) is emitted; no PT output, TAG_IN logic removed.

## Test plan
- Key load: sdi 0x40000000, 0xC2000010, 00010203, 04050607, 08090a0b, 0c0d0e0f -> 6 words accepted, sdi_ready stays 1, no do_valid.
- ENC, 32-byte AD (flags 2) then PT length 31 (flags 2) after ACTKEY/ENC: do shows 0x5200001F, 00000000, 00000000, 00000000, 00000000, 10101010, 10101010, 10101010, 10101000.
- ENC with NPUB 16 bytes, AD 0, PT 4 bytes flags 3 -> CT header, one CT word, TAG header 0x83000010, 4 tag words matching A^K^N, status 0xE0000000 with do_last=1.
- DEC round-trip of previous CT and tag -> original PT, status 0xE0000000; flip one tag bit -> 0xF0000000.
- do_ready held low 5 cycles mid-PT -> do_data frozen, pdi_ready=0, no words lost or duplicated.
- rst asserted mid-segment -> all outputs 0 next edge; fresh key load + ENC produces correct results.
